// File: rtl/hex_scan_display_if.sv
// Bundles the data and display signals of hex_scan_display.
//
// Ports (signals):
//   bin_in      packed hex digits, [3:0] = digit 0 (rightmost)
//   dp_in       decimal point request per digit
//   digit_en    per-digit enable (0 = forced dark)
//   brightness  PWM duty code, all-ones = full on
//   seg         segments a..g (seg[0] = a)
//   dp          decimal point segment
//   an          anode enables, an[0] = digit 0
//   frame_tick  one-cycle pulse at each frame start
//
// Modports:
//   master  drives the data inputs, observes the display pins
//   slave   the display driver itself
interface hex_scan_display_if #(
   parameter int N_DIGITS = 4,
   parameter int BRIGHT_W = 4
);
   logic [4*N_DIGITS-1:0] bin_in;
   logic [N_DIGITS-1:0]   dp_in;
   logic [N_DIGITS-1:0]   digit_en;
   logic [BRIGHT_W-1:0]   brightness;
   logic [6:0]            seg;
   logic                  dp;
   logic [N_DIGITS-1:0]   an;
   logic                  frame_tick;

   modport master (
      output bin_in, dp_in, digit_en, brightness,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  bin_in, dp_in, digit_en, brightness,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver. Scans N_DIGITS seven-segment digits from
// one packed word, with per-digit decimal points and enables, PWM
// brightness, an anti-ghosting guard interval at each slot start, and
// frame-coherent capture of all inputs (no tearing within a frame).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    hex_scan_display_if.slave: bin_in, dp_in, digit_en, brightness
//          in; seg, dp, an, frame_tick out (all outputs registered)
//
// Configuration macro:
//   HEX_LZ_BLANK_EN  leading-zero blanking; digits above the most
//                    significant nonzero nibble go dark unless their dp bit
//                    is set. Digit 0 is never blanked.
module hex_scan_display #(
   parameter int N_DIGITS       = 4,
   parameter int SLOT_CYCLES    = 100000,
   parameter int GUARD_CYCLES   = 16,
   parameter int BRIGHT_W       = 4,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   hex_scan_display_if.slave bus
);

   localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

   logic [SW-1:0]       slot_cnt;
   logic [IW-1:0]       digit_idx;
   logic [BRIGHT_W-1:0] pwm_cnt;

   // Frame-coherent copies of the inputs, loaded only at frame start.
   logic [N_DIGITS-1:0][3:0] shadow_bin;
   logic [N_DIGITS-1:0]      shadow_dp;
   logic [N_DIGITS-1:0]      shadow_en;
   logic [BRIGHT_W-1:0]      shadow_bright;

   logic frame_start;
   logic in_guard;
   logic blanked;
   logic lit;
   logic [3:0] nibble;
   logic [6:0] seg_hi;

   // Active-high a..g pattern for one hex nibble.
   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign frame_start = (digit_idx == '0) && (slot_cnt == '0);
   assign in_guard    = (slot_cnt < SW'(GUARD_CYCLES));
   assign nibble      = shadow_bin[digit_idx];
   assign seg_hi      = hex_decode(nibble);

`ifdef HEX_LZ_BLANK_EN
   logic [IW-1:0] msd_idx;

   // Index of the most significant nonzero nibble (0 when the word is 0),
   // so digit 0 can never sit above it.
   always_comb begin
      msd_idx = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (shadow_bin[i] != 4'h0) msd_idx = IW'(i);
      end
   end

   assign blanked = (digit_idx > msd_idx) && !shadow_dp[digit_idx];
`else
   assign blanked = 1'b0;
`endif

   assign lit = !in_guard && shadow_en[digit_idx] && !blanked &&
                (pwm_cnt <= shadow_bright);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt      <= '0;
         digit_idx     <= '0;
         pwm_cnt       <= '0;
         shadow_bin    <= '0;
         shadow_dp     <= '0;
         shadow_en     <= '0;
         shadow_bright <= '0;
         bus.seg        <= SEG_OFF;
         bus.dp         <= DP_OFF;
         bus.an         <= AN_OFF;
         bus.frame_tick <= 1'b0;
      end else begin
         if (slot_cnt == SW'(SLOT_CYCLES - 1)) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == IW'(N_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end

         // Held at 0 through the guard so the first active cycle sees 0.
         pwm_cnt <= in_guard ? '0 : pwm_cnt + 1'b1;

         if (frame_start) begin
            shadow_bin    <= bus.bin_in;
            shadow_dp     <= bus.dp_in;
            shadow_en     <= bus.digit_en;
            shadow_bright <= bus.brightness;
         end

         bus.frame_tick <= frame_start;

         if (lit) begin
            bus.an  <= AN_ACTIVE_LOW ? ~(N_DIGITS'(1) << digit_idx)
                                     :  (N_DIGITS'(1) << digit_idx);
            bus.seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            bus.dp  <= SEG_ACTIVE_LOW ? ~shadow_dp[digit_idx] : shadow_dp[digit_idx];
         end else begin
            bus.an  <= AN_OFF;
            bus.seg <= SEG_OFF;
            bus.dp  <= DP_OFF;
         end
      end
   end

endmodule

// File: tb/tb_hex_scan_display.sv
module tb_hex_scan_display;

   localparam int N     = 4;
   localparam int SLOT  = 8;
   localparam int GUARD = 2;
   localparam int BW    = 2;
   localparam int FRAME = N * SLOT;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   hex_scan_display_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus ();

   hex_scan_display #(
      .N_DIGITS(N), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD),
      .BRIGHT_W(BW), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;   // rising edges since reset release

   // Reference model: the inputs captured at the latest frame start.
   logic [4*N-1:0] m_bin;
   logic [N-1:0]   m_dp, m_en;
   logic [BW-1:0]  m_br;

   logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
      end
   endtask

   task automatic chk_reset_pins(input string tag);
      chk({tag, "_an"}, 16'(bus.an), 16'hF);
      chk({tag, "_seg"}, 16'(bus.seg), 16'h7F);
      chk({tag, "_dp"}, 16'(bus.dp), 16'h1);
      chk({tag, "_tick"}, 16'(bus.frame_tick), 16'h0);
   endtask

   // Pins after an edge reflect the counter position held before it.
   task automatic check_pos(input int pos);
      int d, sc, pwm;
      logic lit;
      logic [3:0] nib;
      logic [N-1:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      d   = pos / SLOT;
      sc  = pos % SLOT;
      lit = 1'b0;
      if (sc >= GUARD) begin
         pwm = (sc - GUARD) % (1 << BW);
         lit = m_en[d] && (pwm <= int'(m_br));
`ifdef HEX_LZ_BLANK_EN
         if (d > 0 && (m_bin >> (4 * d)) == '0 && !m_dp[d]) lit = 1'b0;
`endif
      end
      nib   = m_bin[4*d +: 4];
      e_an  = lit ? ~(N'(1) << d) : '1;
      e_seg = lit ? ~hex7[nib] : 7'h7F;
      e_dp  = lit ? ~m_dp[d] : 1'b1;
      chk("an", 16'(bus.an), 16'(e_an));
      chk("seg", 16'(bus.seg), 16'(e_seg));
      chk("dp", 16'(bus.dp), 16'(e_dp));
      chk("frame_tick", 16'(bus.frame_tick), 16'(pos == 0));
      chk("an_onehot", 16'($countones(~bus.an) <= 1), 16'h1);
   endtask

   task automatic run(input int n);
      int pos;
      for (int i = 0; i < n; i++) begin
         pos = cyc % FRAME;
         if (pos == 0) begin
            m_bin = bus.bin_in;
            m_dp  = bus.dp_in;
            m_en  = bus.digit_en;
            m_br  = bus.brightness;
         end
         @(posedge clk);
         #1;
         cyc++;
         check_pos(pos);
      end
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) bus.bin_in     = 16'($urandom);
         if ($urandom_range(0, 9) == 0) bus.dp_in      = 4'($urandom);
         if ($urandom_range(0, 9) == 0) bus.digit_en   = 4'($urandom);
         if ($urandom_range(0, 9) == 0) bus.brightness = 2'($urandom);
         if ($urandom_range(0, 11) == 0) bus.bin_in    = 16'($urandom_range(0, 255));
         run(1);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.bin_in     = 16'h1234;
      bus.dp_in      = 4'h0;
      bus.digit_en   = 4'hF;
      bus.brightness = 2'd3;

      // Held in reset across edges.
      repeat (3) @(posedge clk);
      #1;
      chk_reset_pins("reset");
      rst_n = 1'b1;
      cyc   = 0;

      // Full brightness, all digits, 1234.
      run(2 * FRAME);

      // Change the word inside digit 1's slot: takes effect next frame.
      run(SLOT + 3);
      bus.bin_in = 16'hABCD;
      run(FRAME - SLOT - 3 + FRAME);

      // Low duty codes.
      bus.brightness = 2'd0;
      run(FRAME);
      bus.brightness = 2'd1;
      run(FRAME);

      // Disabled digits and a dp request on a disabled digit.
      bus.brightness = 2'd3;
      bus.digit_en   = 4'b0101;
      bus.dp_in      = 4'b0010;
      run(2 * FRAME);

      // Randomized inputs changing at arbitrary cycles.
      run_random(8 * FRAME);

      // Asynchronous reset in the middle of digit 2's slot.
      run(((2 * SLOT + 5) - (cyc % FRAME) + FRAME) % FRAME);
      rst_n = 1'b0;
      #1;
      chk_reset_pins("midreset");
      @(posedge clk);
      #1;
      chk_reset_pins("midreset_hold");
      rst_n = 1'b1;
      cyc   = 0;

      // Leading-zero cases (plain display when blanking is off).
      bus.bin_in     = 16'h0050;
      bus.dp_in      = 4'h0;
      bus.digit_en   = 4'hF;
      bus.brightness = 2'd3;
      run(FRAME);
      bus.bin_in = 16'h0000;
      run(FRAME);
      bus.dp_in = 4'b1000;
      run(FRAME);

      run_random(4 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
